hyper_gray_ptr_rx: RTL and testbench



---
 rtl/hyper_gray_ptr_rx.sv | 147 ++++++++++++++
 tb/tb_hyper_gray_ptr_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_gray_ptr_rx.sv
`default_nettype none
// ============================================================================
// Module   : hyper_gray_ptr_rx
// Purpose  : Receive end of a gray-coded pointer crossing for the hyperbus
//            CDC FIFOs. Synchronizes the remote gray write pointer into the
//            local clock, decodes it to binary, tracks the local read pointer
//            under a pop handshake and returns it gray-coded. Reports fill
//            level, empty status and a sticky pointer-integrity error.
// Ports    : clk_i        local (read-side) clock
//            rst_i        asynchronous active-high reset
//            wptr_gray_i  gray write pointer, asynchronous to clk_i
//            pop_i        request removal of one entry
//            clr_err_i    synchronous clear of err_o
//            pop_ok_o     pop accepted this cycle (combinational)
//            raddr_o      current read address
//            rptr_gray_o  registered gray read pointer to remote domain
//            level_o      number of valid entries, 0..DEPTH
//            empty_o      level_o == 0
//            err_o        sticky pointer-integrity error
// Revision : 1.0 - initial release
// ============================================================================
module hyper_gray_ptr_rx #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2   // legal range 2..3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W:0]   wptr_gray_i,
  input  logic              pop_i,
  input  logic              clr_err_i,
  output logic              pop_ok_o,
  output logic [ADDR_W-1:0] raddr_o,
  output logic [ADDR_W:0]   rptr_gray_o,
  output logic [ADDR_W:0]   level_o,
  output logic              empty_o,
  output logic              err_o
);

  localparam int            PW    = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // --------------------------------------------------------------------------
  // Synchronizer chain: plain flop-to-flop, nothing between stages.
  // --------------------------------------------------------------------------
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] wsync;

  always_comb begin
    sync_d[0] = wptr_gray_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign wsync = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Pointer state
  // --------------------------------------------------------------------------
  logic [PW-1:0] wptr_bin_q,   wptr_bin_d;
  logic [PW-1:0] wgray_prev_q, wgray_prev_d;
  logic [PW-1:0] rptr_bin_q,   rptr_bin_d;
  logic [PW-1:0] rptr_gray_q,  rptr_gray_d;
  logic          err_q,        err_d;

  logic [PW-1:0] level;
  logic [PW-1:0] rptr_inc;
  logic [PW-1:0] gray_diff;
  logic          empty;
  logic          pop_ok;
  logic          multi_bit_step;
  logic          level_over;

  assign level    = wptr_bin_q - rptr_bin_q;   // wrap bit makes modulo math exact
  assign empty    = (level == '0);
  assign pop_ok   = pop_i & ~empty;
  assign rptr_inc = rptr_bin_q + PW'(1);

  // A legal gray stream changes at most one bit between samples; x & (x-1)
  // is nonzero exactly when more than one bit of x is set.
  assign gray_diff      = wsync ^ wgray_prev_q;
  assign multi_bit_step = |(gray_diff & (gray_diff - PW'(1)));
  assign level_over     = (level > DEPTH);

  always_comb begin
    // Gray to binary: bit i is the XOR of all gray bits at or above i.
    wptr_bin_d = '0;
    for (int i = 0; i < PW; i++) begin
      wptr_bin_d[i] = ^(wsync >> i);
    end
    wgray_prev_d = wsync;

    rptr_bin_d  = rptr_bin_q;
    rptr_gray_d = rptr_gray_q;
    if (pop_ok) begin
      rptr_bin_d  = rptr_inc;
      rptr_gray_d = rptr_inc ^ (rptr_inc >> 1);
    end

    // Clear first so a concurrent error condition overrides it.
    err_d = err_q;
    if (clr_err_i) begin
      err_d = 1'b0;
    end
    if (multi_bit_step || level_over) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_bin_q   <= '0;
      wgray_prev_q <= '0;
      rptr_bin_q   <= '0;
      rptr_gray_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      wptr_bin_q   <= wptr_bin_d;
      wgray_prev_q <= wgray_prev_d;
      rptr_bin_q   <= rptr_bin_d;
      rptr_gray_q  <= rptr_gray_d;
      err_q        <= err_d;
    end
  end

  assign pop_ok_o    = pop_ok;
  assign raddr_o     = rptr_bin_q[ADDR_W-1:0];
  assign rptr_gray_o = rptr_gray_q;
  assign level_o     = level;
  assign empty_o     = empty;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hyper_gray_ptr_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyper_gray_ptr_rx
// Purpose  : Self-checking bench for hyper_gray_ptr_rx (ADDR_W=3,
//            SYNC_STAGES=2). A table of hand-computed vectors covers reset,
//            fill latency, pops, pointer wrap and simultaneous pop/advance;
//            hand-written sequences cover the error flag and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyper_gray_ptr_rx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] wptr_gray_i = 4'd0;
  logic       pop_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic       pop_ok_o;
  logic [2:0] raddr_o;
  logic [3:0] rptr_gray_o;
  logic [3:0] level_o;
  logic       empty_o;
  logic       err_o;

  int n_cmp = 0;
  int n_bad = 0;

  hyper_gray_ptr_rx #(
    .ADDR_W      (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wptr_gray_i (wptr_gray_i),
    .pop_i       (pop_i),
    .clr_err_i   (clr_err_i),
    .pop_ok_o    (pop_ok_o),
    .raddr_o     (raddr_o),
    .rptr_gray_o (rptr_gray_o),
    .level_o     (level_o),
    .empty_o     (empty_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] wg;
    logic       pop;
    logic       clr;
    logic [3:0] lvl;
    logic       emp;
    logic       pok;
    logic [2:0] ra;
    logic [3:0] rg;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] wg, input logic pop, input logic clr,
                     input logic [3:0] lvl, input logic emp, input logic pok,
                     input logic [2:0] ra, input logic [3:0] rg, input logic err);
    vec_t v;
    v.wg = wg; v.pop = pop; v.clr = clr; v.lvl = lvl; v.emp = emp;
    v.pok = pok; v.ra = ra; v.rg = rg; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    wptr_gray_i = 4'd0;
    pop_i = 1'b0;
    clr_err_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    // ---------------- vector table ----------------
    //   wg     pop   clr  lvl  emp pok ra  rg     err
    // reset state, pop ignored while empty
    for (int i = 0; i < 5; i++) add(4'b0000, 1, 0, 0, 1, 0, 0, 4'b0000, 0);
    // fill latency: 0001 at step 5, 0011 at step 6
    add(4'b0001, 0, 0, 0, 1, 0, 0, 4'b0000, 0);   // s5
    add(4'b0011, 0, 0, 0, 1, 0, 0, 4'b0000, 0);   // s6
    add(4'b0011, 0, 0, 0, 1, 0, 0, 4'b0000, 0);   // s7
    add(4'b0011, 0, 0, 1, 0, 0, 0, 4'b0000, 0);   // s8 level 1, 3 edges after change
    add(4'b0011, 1, 0, 2, 0, 1, 0, 4'b0000, 0);   // s9 pop 1
    add(4'b0011, 1, 0, 1, 0, 1, 1, 4'b0001, 0);   // s10 pop 2
    add(4'b0011, 1, 0, 0, 1, 0, 2, 4'b0011, 0);   // s11 pop refused
    // walk write pointer to 9, read pointer to 7
    add(4'b0010, 0, 0, 0, 1, 0, 2, 4'b0011, 0);   // s12
    add(4'b0110, 0, 0, 0, 1, 0, 2, 4'b0011, 0);   // s13
    add(4'b0111, 0, 0, 0, 1, 0, 2, 4'b0011, 0);   // s14
    add(4'b0101, 1, 0, 1, 0, 1, 2, 4'b0011, 0);   // s15 w3 r2
    add(4'b0100, 1, 0, 1, 0, 1, 3, 4'b0010, 0);   // s16 w4 r3
    add(4'b1100, 1, 0, 1, 0, 1, 4, 4'b0110, 0);   // s17 w5 r4
    add(4'b1101, 1, 0, 1, 0, 1, 5, 4'b0111, 0);   // s18 w6 r5
    add(4'b1101, 1, 0, 1, 0, 1, 6, 4'b0101, 0);   // s19 w7 r6
    add(4'b1101, 0, 0, 1, 0, 0, 7, 4'b0100, 0);   // s20 w8 r7
    add(4'b1101, 0, 0, 2, 0, 0, 7, 4'b0100, 0);   // s21 w9 r7 -> level 2
    // continue through the wrap
    add(4'b1111, 1, 0, 2, 0, 1, 7, 4'b0100, 0);   // s22 w9 r7
    add(4'b1110, 1, 0, 1, 0, 1, 0, 4'b1100, 0);   // s23 w9 r8
    add(4'b1010, 0, 0, 0, 1, 0, 1, 4'b1101, 0);   // s24 w9 r9
    add(4'b1011, 0, 0, 1, 0, 0, 1, 4'b1101, 0);   // s25 w10 r9
    add(4'b1001, 1, 0, 2, 0, 1, 1, 4'b1101, 0);   // s26 w11 r9
    add(4'b1000, 1, 0, 2, 0, 1, 2, 4'b1111, 0);   // s27 w12 r10
    add(4'b0000, 1, 0, 2, 0, 1, 3, 4'b1110, 0);   // s28 w13 r11
    add(4'b0000, 1, 0, 2, 0, 1, 4, 4'b1010, 0);   // s29 w14 r12
    add(4'b0000, 1, 0, 2, 0, 1, 5, 4'b1011, 0);   // s30 w15 r13
    add(4'b0000, 1, 0, 2, 0, 1, 6, 4'b1001, 0);   // s31 w0 r14 (wrapped)
    add(4'b0000, 1, 0, 1, 0, 1, 7, 4'b1000, 0);   // s32 w0 r15
    add(4'b0000, 0, 0, 0, 1, 0, 0, 4'b0000, 0);   // s33 w0 r0
    // simultaneous pop and write advance at level 3
    add(4'b0001, 0, 0, 0, 1, 0, 0, 4'b0000, 0);   // s34
    add(4'b0011, 0, 0, 0, 1, 0, 0, 4'b0000, 0);   // s35
    add(4'b0010, 0, 0, 0, 1, 0, 0, 4'b0000, 0);   // s36
    add(4'b0110, 0, 0, 1, 0, 0, 0, 4'b0000, 0);   // s37
    add(4'b0110, 0, 0, 2, 0, 0, 0, 4'b0000, 0);   // s38
    add(4'b0110, 1, 0, 3, 0, 1, 0, 4'b0000, 0);   // s39 pop while w 3->4
    add(4'b0110, 0, 0, 3, 0, 0, 1, 4'b0001, 0);   // s40
    add(4'b0110, 0, 0, 3, 0, 0, 1, 4'b0001, 0);   // s41

    do_reset();
    foreach (vecs[k]) begin
      wptr_gray_i = vecs[k].wg;
      pop_i       = vecs[k].pop;
      clr_err_i   = vecs[k].clr;
      #1;
      chk($sformatf("s%0d level", k),  level_o,     vecs[k].lvl);
      chk($sformatf("s%0d empty", k),  empty_o,     vecs[k].emp);
      chk($sformatf("s%0d pop_ok", k), pop_ok_o,    vecs[k].pok);
      chk($sformatf("s%0d raddr", k),  raddr_o,     vecs[k].ra);
      chk($sformatf("s%0d rgray", k),  rptr_gray_o, vecs[k].rg);
      chk($sformatf("s%0d err", k),    err_o,       vecs[k].err);
      tick();
    end

    // ---------------- illegal two-bit jump ----------------
    do_reset();
    wptr_gray_i = 4'b0011;
    pop_i = 1'b0;
    #1 chk("jump err e0", err_o, 1'b0);
    tick(); chk("jump err e1", err_o, 1'b0);
    tick(); chk("jump err e2", err_o, 1'b0);
    tick(); chk("jump err e3", err_o, 1'b1);
    tick(); chk("jump err sticky", err_o, 1'b1);
    tick(); chk("jump err sticky2", err_o, 1'b1);
    chk("jump level", level_o, 4'd2);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    #1 chk("jump err cleared", err_o, 1'b0);
    tick(); chk("jump err stays clear", err_o, 1'b0);

    // ---------------- level 9 via legal walk ----------------
    do_reset();
    for (int k = 0; k < 12; k++) begin
      wptr_gray_i = gray((k < 9) ? 4'(k + 1) : 4'd9);
      #1;
      if (k == 10) begin
        chk("lvl8 level", level_o, 4'd8);
        chk("lvl8 err", err_o, 1'b0);
      end
      if (k == 11) begin
        chk("lvl9 level", level_o, 4'd9);
        chk("lvl9 err pre", err_o, 1'b0);
      end
      tick();
    end
    chk("lvl9 err set", err_o, 1'b1);
    // clear coincident with a live error condition: set wins
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    #1 chk("set beats clear", err_o, 1'b1);

    // ---------------- asynchronous reset mid-operation ----------------
    pop_i = 1'b1;
    tick(); tick();
    pop_i = 1'b0;
    #1 chk("pre-reset raddr", raddr_o, 3'd2);
    chk("pre-reset rgray", rptr_gray_o, 4'b0011);
    #2 rst_i = 1'b1;   // mid-cycle, no clock edge
    #1;
    chk("async rst raddr", raddr_o, 3'd0);
    chk("async rst rgray", rptr_gray_o, 4'b0000);
    chk("async rst level", level_o, 4'd0);
    chk("async rst empty", empty_o, 1'b1);
    chk("async rst err", err_o, 1'b0);
    wptr_gray_i = 4'd0;
    tick();
    rst_i = 1'b0;
    tick();
    chk("post-reset level", level_o, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
